psram_arbiter: RTL and testbench
================================

Name: psram_arbiter

Overview:
- Two-client request arbiter sitting directly upstream of the PSRAM controller. It serialises word/byte read and write requests from a CPU-side port (A) and a DMA/video-side port (B) onto the controller's single read/write pulse interface.
- It holds command fields stable for the full transaction and returns read data with a one-cycle acknowledge.
- It never issues while the controller reports busy, including the ~160 us power-up configuration window.

Parameters:
- START_TIMEOUT, 7, max cycles to wait in WAIT_START for mem_busy to rise after an issue.

Ports:
- clk  in  1  system clock (same clock as the controller)
- resetn  in  1  asynchronous active-low reset
- a_req  in  1  port A request; held high with fields stable until a_ack
- a_we  in  1  1=write, 0=read
- a_byte  in  1  byte write; a_addr[0] selects the upper byte of a_wdata
- a_addr  in  22  byte address
- a_wdata  in  16  write data
- a_rdata  out  16  read data, valid in the a_ack cycle
- a_ack  out  1  one-cycle completion pulse
- b_req, b_we, b_byte, b_addr, b_wdata, b_rdata, b_ack: identical to port A for port B
- mem_read  out  1  one-cycle read command to the controller
- mem_write  out  1  one-cycle write command to the controller
- mem_addr  out  22  command address
- mem_din  out  16  write data
- mem_byte_write  out  1  byte-write qualifier
- mem_dout  in  16  controller read data
- mem_busy  in  1  controller busy
- timeout_err  out  1  sticky: set when mem_busy failed to rise within START_TIMEOUT

Behaviour:
- All outputs are registered.
- Reset values: mem_read=0, mem_write=0, mem_addr=0, mem_din=0, mem_byte_write=0, a/b_rdata=0, a/b_ack=0, timeout_err=0, state=IDLE, rr_last=B.
- FSM states: IDLE, ISSUE, WAIT_START, WAIT_END, DONE.
- IDLE: if mem_busy=0 and any req is pending, grant one port:
  - latch its addr/wdata/byte/we into mem_addr/mem_din/mem_byte_write;
  - record the granted port;
  - assert mem_read (we=0) or mem_write (we=1);
  - go to ISSUE.
  - If mem_busy=1, stay in IDLE. This covers controller init after reset.
- ISSUE: lasts one cycle with the command pulse high. Next cycle mem_read/mem_write drop to 0; go to WAIT_START and clear the timeout counter.
- WAIT_START: mem_busy=1 → WAIT_END. Otherwise increment the counter. At START_TIMEOUT, set timeout_err, go to DONE, and return no new read data (rdata keeps its old value).
- WAIT_END: mem_busy=0 → DONE.
- DONE: for one cycle:
  - pulse the granted port's ack;
  - on a read, load that port's rdata from mem_dout in the same edge, so rdata is valid while ack=1;
  - go to IDLE.
- mem_addr, mem_din and mem_byte_write stay constant from ISSUE through DONE. The controller samples addr[0] and byte_write mid-write, so they must not change.
- Latency, idle controller: req seen at edge 0 → mem_read high in cycle 1 → ack at the controller's busy fall + 1 cycle.
- The arbiter issues a new request no earlier than one cycle after DONE. Back-to-back requests therefore each have a gap of at least one IDLE cycle.
- Arbitration: fixed priority, A over B, unless PSRAM_ARB_RR_EN is defined.
- A request deasserted before ack is illegal; the arbiter ignores the change, because its fields are already latched.
- A port with req held high after ack: that request is treated as a new request (clients drop req in the ack cycle).
- The non-granted port's ack stays 0 and its rdata is unchanged.
- The latched port id selects the ack/rdata target, never the live req lines.
- Asynchronous reset mid-transaction: state returns to IDLE, outputs take their reset values, and no ack is issued for the aborted request.
- timeout_err is cleared only by reset.

Optional Feature:
- PSRAM_ARB_RR_EN defined: round-robin arbitration. When both ports request in IDLE, grant the port that was not granted last (rr_last); rr_last updates on every grant. A single requester is always granted.
- Undefined: strict priority, A always wins simultaneous requests; rr_last is unused.

Test Plan:
1. Hold mem_busy=1 for 100 cycles after reset while a_req=1 → mem_read stays 0. After mem_busy falls, mem_read pulses exactly once with mem_addr=a_addr.
2. A read of 0x000124, controller model busy for 12 cycles returning 0xBEEF → a_ack pulses once, a_rdata=0xBEEF in the ack cycle, mem_addr is stable throughout.
3. A byte write, addr=0x000001, wdata=0x5A00 → one mem_write pulse, mem_byte_write=1, mem_addr[0]=1 held until busy falls, then a_ack; a_rdata unchanged.
4. a_req and b_req both asserted and held, 4 transactions:
   - without PSRAM_ARB_RR_EN → grant order A,A,A,A while a_req is re-raised;
   - with the macro → A,B,A,B.
5. Controller model never raises busy → after 7 WAIT_START cycles, timeout_err=1 and a_ack pulses. The next request proceeds normally; timeout_err stays 1.
6. resetn pulsed low during WAIT_END → no ack, all outputs at reset values immediately (asynchronous). After reset the pending request is reissued once mem_busy=0.

Source files
------------

// File: rtl/psram_arbiter_if.sv
// psram_arbiter_if: client ports A/B, controller command port and status of the PSRAM arbiter.
// Latency: none, plain wires.
// Backpressure: carried by the req/ack handshake per client and mem_busy from the controller.
interface psram_arbiter_if;
   // Client port A
   logic        a_req;
   logic        a_we;
   logic        a_byte;
   logic [21:0] a_addr;
   logic [15:0] a_wdata;
   logic [15:0] a_rdata;
   logic        a_ack;
   // Client port B
   logic        b_req;
   logic        b_we;
   logic        b_byte;
   logic [21:0] b_addr;
   logic [15:0] b_wdata;
   logic [15:0] b_rdata;
   logic        b_ack;
   // Controller command side
   logic        mem_read;
   logic        mem_write;
   logic [21:0] mem_addr;
   logic [15:0] mem_din;
   logic        mem_byte_write;
   logic [15:0] mem_dout;
   logic        mem_busy;
   // Status
   logic        timeout_err;

   // Arbiter side
   modport slave (
      input  a_req, a_we, a_byte, a_addr, a_wdata,
      output a_rdata, a_ack,
      input  b_req, b_we, b_byte, b_addr, b_wdata,
      output b_rdata, b_ack,
      output mem_read, mem_write, mem_addr, mem_din, mem_byte_write,
      input  mem_dout, mem_busy,
      output timeout_err
   );

   // Clients plus controller side
   modport master (
      output a_req, a_we, a_byte, a_addr, a_wdata,
      input  a_rdata, a_ack,
      output b_req, b_we, b_byte, b_addr, b_wdata,
      input  b_rdata, b_ack,
      input  mem_read, mem_write, mem_addr, mem_din, mem_byte_write,
      output mem_dout, mem_busy,
      input  timeout_err
   );
endinterface

// File: rtl/psram_arbiter.sv
// psram_arbiter: serialises A (CPU) and B (DMA/video) word/byte requests onto the PSRAM controller pulse interface.
// Latency: command pulse the cycle after a request is seen with the controller idle; ack one cycle after mem_busy falls.
// Backpressure: nothing issues while mem_busy is high; each client holds req until its one-cycle ack.
// Build option: define PSRAM_ARB_RR_EN for round-robin between A and B; otherwise A has fixed priority.
module psram_arbiter #(
   parameter int START_TIMEOUT = 7
) (
   input  logic           clk,
   input  logic           resetn,
   psram_arbiter_if.slave bus
);

   localparam int            CW      = $clog2(START_TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(START_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_START,
      WAIT_END,
      DONE
   } state_t;

   state_t        state;
   logic          gnt_b;     // port owning the transaction in flight (1 = B)
   logic          lat_we;    // latched direction of the transaction in flight
   logic [CW-1:0] to_cnt;    // cycles spent in WAIT_START without busy

   logic          pick_b;
   logic          sel_we;
   logic          sel_byte;
   logic [21:0]   sel_addr;
   logic [15:0]   sel_wdata;

`ifdef PSRAM_ARB_RR_EN
   logic          rr_last;   // port granted most recently (1 = B)
`endif

   // Pick the port to grant and mux its command fields
   always_comb begin
      pick_b = bus.b_req & ~bus.a_req;
`ifdef PSRAM_ARB_RR_EN
      if (bus.a_req && bus.b_req) begin
         pick_b = ~rr_last;
      end
`endif
      sel_we    = pick_b ? bus.b_we    : bus.a_we;
      sel_byte  = pick_b ? bus.b_byte  : bus.a_byte;
      sel_addr  = pick_b ? bus.b_addr  : bus.a_addr;
      sel_wdata = pick_b ? bus.b_wdata : bus.a_wdata;
   end

   // Transaction sequencer; acks and rdata are set on the edge entering DONE so they are valid during DONE
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state              <= IDLE;
         gnt_b              <= 1'b0;
         lat_we             <= 1'b0;
         to_cnt             <= '0;
         bus.mem_read       <= 1'b0;
         bus.mem_write      <= 1'b0;
         bus.mem_addr       <= '0;
         bus.mem_din        <= '0;
         bus.mem_byte_write <= 1'b0;
         bus.a_rdata        <= '0;
         bus.b_rdata        <= '0;
         bus.a_ack          <= 1'b0;
         bus.b_ack          <= 1'b0;
         bus.timeout_err    <= 1'b0;
`ifdef PSRAM_ARB_RR_EN
         rr_last            <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               // mem_busy high also covers the controller's power-up configuration window
               if (!bus.mem_busy && (bus.a_req || bus.b_req)) begin
                  gnt_b              <= pick_b;
                  lat_we             <= sel_we;
                  bus.mem_addr       <= sel_addr;
                  bus.mem_din        <= sel_wdata;
                  bus.mem_byte_write <= sel_byte;
                  bus.mem_read       <= ~sel_we;
                  bus.mem_write      <= sel_we;
`ifdef PSRAM_ARB_RR_EN
                  rr_last            <= pick_b;
`endif
                  state              <= ISSUE;
               end
            end
            ISSUE: begin
               bus.mem_read  <= 1'b0;
               bus.mem_write <= 1'b0;
               to_cnt        <= '0;
               state         <= WAIT_START;
            end
            WAIT_START: begin
               if (bus.mem_busy) begin
                  state <= WAIT_END;
               end else if (to_cnt == TO_LAST) begin
                  // Controller never accepted: finish with an ack but leave rdata untouched
                  bus.timeout_err <= 1'b1;
                  bus.a_ack       <= ~gnt_b;
                  bus.b_ack       <= gnt_b;
                  state           <= DONE;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            WAIT_END: begin
               if (!bus.mem_busy) begin
                  bus.a_ack <= ~gnt_b;
                  bus.b_ack <= gnt_b;
                  if (!lat_we) begin
                     if (gnt_b) begin
                        bus.b_rdata <= bus.mem_dout;
                     end else begin
                        bus.a_rdata <= bus.mem_dout;
                     end
                  end
                  state <= DONE;
               end
            end
            DONE: begin
               bus.a_ack <= 1'b0;
               bus.b_ack <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_psram_arbiter.sv
// tb_psram_arbiter: randomized clients and a PSRAM controller model drive the arbiter; a scoreboard checks grants and acks.
// Latency: expected ack one cycle after busy falls, or START_TIMEOUT+1 cycles after issue when the controller ignores it.
// Backpressure: clients hold req until ack; the controller model keeps busy high for a random or fixed duration.
module tb_psram_arbiter;

   localparam int START_TIMEOUT = 7;
`ifdef PSRAM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   typedef struct {
      logic        we;
      logic        byt;
      logic [21:0] addr;
      logic [15:0] wdata;
      int          gap;
   } txn_t;

   typedef struct {
      int   port;
      txn_t t;
      bit   timeout;
      int   issue_cyc;
   } out_t;

   logic clk    = 1'b0;
   logic resetn = 1'b0;

   psram_arbiter_if bus();

   psram_arbiter #(.START_TIMEOUT(START_TIMEOUT)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   txn_t        cq[2][$];     // commands waiting for each client
   txn_t        exp_q[2][$];  // requests raised but not yet granted
   bit          busy_cli[2];
   out_t        cur;
   bit          outst     = 0;
   bit          stab_bad  = 0;
   int          cyc       = 0;
   int          fall_cyc  = -100;
   int          issue_cnt = 0;
   bit          req_at[2];
   bit          busy_at   = 1'b1;
   bit          rr_last_m = 1'b1;
   bit          terr_m    = 1'b0;
   logic [15:0] rd_m[2];
   int          grant_log[$];
   int          init_cnt  = 105;
   int          bcnt      = 0;
   bit          force_ign = 0;
   bit          rand_ign  = 0;
   int          dur_fix   = 0;
   logic [21:0] ctl_addr  = '0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Controller read data as a function of address
   function automatic logic [15:0] ctrl_data(input logic [21:0] a);
      if (a == 22'h000124) return 16'hBEEF;
      return {a[7:0] ^ 8'h3C, a[15:8] + 8'h11} ^ {10'd0, a[21:16]};
   endfunction

   task automatic drive(input int p, input txn_t t);
      if (p == 0) begin
         bus.a_we = t.we; bus.a_byte = t.byt; bus.a_addr = t.addr; bus.a_wdata = t.wdata; bus.a_req = 1'b1;
      end else begin
         bus.b_we = t.we; bus.b_byte = t.byt; bus.b_addr = t.addr; bus.b_wdata = t.wdata; bus.b_req = 1'b1;
      end
   endtask

   task automatic set_req(input int p, input logic r);
      if (p == 0) bus.a_req = r;
      else        bus.b_req = r;
   endtask

   // Client: raise a request, hold it until ack, then drop it or present the next one at once
   task automatic client(input int p);
      txn_t t;
      int   w;
      bit   got;
      forever begin
         @(negedge clk);
         if (cq[p].size() != 0) begin
            busy_cli[p] = 1'b1;
            t = cq[p].pop_front();
            if (t.gap > 0) begin
               set_req(p, 1'b0);
               repeat (t.gap) @(negedge clk);
            end
            drive(p, t);
            exp_q[p].push_back(t);
            w   = 0;
            got = 1'b0;
            while (!got && w < 400) begin
               @(negedge clk);
               w++;
               got = (p == 0) ? bus.a_ack : bus.b_ack;
            end
            check((p == 0) ? "a_ack_wait" : "b_ack_wait", 64'(got), 64'(1));
            if (cq[p].size() == 0 || cq[p][0].gap != 0) set_req(p, 1'b0);
            busy_cli[p] = 1'b0;
         end
      end
   endtask

   task automatic push_cmd(input int p, input logic we, input logic byt, input logic [21:0] addr,
                           input logic [15:0] wdata, input int gap);
      txn_t t;
      t.we = we; t.byt = byt; t.addr = addr; t.wdata = wdata; t.gap = gap;
      cq[p].push_back(t);
   endtask

   task automatic wait_idle(input int limit);
      int n    = 0;
      bit done = 1'b0;
      while (!done && n < limit) begin
         @(negedge clk);
         #1;
         n++;
         done = cq[0].size() == 0 && cq[1].size() == 0 && exp_q[0].size() == 0 &&
                exp_q[1].size() == 0 && !outst && !busy_cli[0] && !busy_cli[1];
      end
      check("drain", 64'(done), 64'(1));
   endtask

   // Request lines and busy as the arbiter sees them at each active edge
   always @(posedge clk) begin
      req_at[0] = bus.a_req;
      req_at[1] = bus.b_req;
      busy_at   = bus.mem_busy;
   end

   // Scoreboard monitor plus controller model, evaluated away from the active edge
   always @(negedge clk) begin
      int   g;
      int   p;
      bit   started;
      txn_t t;
      cyc++;
      started = 1'b0;
      if (!resetn) begin
         if (outst) exp_q[cur.port].push_front(cur.t);
         outst     = 1'b0;
         rr_last_m = 1'b1;
         terr_m    = 1'b0;
         rd_m[0]   = '0;
         rd_m[1]   = '0;
      end else begin
         // Command fields must hold, and no second pulse, while a transaction is in flight
         if (outst) begin
            if (bus.mem_addr !== cur.t.addr || bus.mem_din !== cur.t.wdata ||
                bus.mem_byte_write !== cur.t.byt || bus.mem_read || bus.mem_write)
               stab_bad = 1'b1;
         end
         if (bus.a_ack || bus.b_ack) begin
            p = bus.b_ack ? 1 : 0;
            check("ack_outstanding", 64'(outst), 64'(1));
            if (outst) begin
               check("ack_port", 64'(p), 64'(cur.port));
               check("ack_single", 64'(bus.a_ack & bus.b_ack), 64'(0));
               if (cur.timeout) begin
                  terr_m = 1'b1;
                  check("timeout_latency", 64'(cyc - cur.issue_cyc), 64'(START_TIMEOUT + 1));
               end else begin
                  check("ack_latency", 64'(cyc - fall_cyc), 64'(1));
                  if (!cur.t.we) rd_m[cur.port] = ctrl_data(cur.t.addr);
               end
               check("a_rdata", 64'(bus.a_rdata), 64'(rd_m[0]));
               check("b_rdata", 64'(bus.b_rdata), 64'(rd_m[1]));
               check("timeout_err", 64'(bus.timeout_err), 64'(terr_m));
               check("fields_stable", 64'(stab_bad), 64'(0));
               outst = 1'b0;
            end
         end
         if ((bus.mem_read || bus.mem_write) && !outst) begin
            issue_cnt++;
            check("issue_ctrl_idle", 64'(busy_at), 64'(0));
            check("issue_has_req", 64'(req_at[0] | req_at[1]), 64'(1));
            if (req_at[0] && req_at[1]) g = RR ? (rr_last_m ? 0 : 1) : 0;
            else                        g = req_at[1] ? 1 : 0;
            rr_last_m = g[0];
            grant_log.push_back(g);
            check("grant_pending", 64'(exp_q[g].size() > 0), 64'(1));
            if (exp_q[g].size() > 0) begin
               t = exp_q[g].pop_front();
               check("grant_fields",
                     64'({bus.mem_write, bus.mem_read, bus.mem_byte_write, bus.mem_addr, bus.mem_din}),
                     64'({t.we, ~t.we, t.byt, t.addr, t.wdata}));
               cur.port      = g;
               cur.t         = t;
               cur.issue_cyc = cyc;
               cur.timeout   = force_ign || (rand_ign && $urandom_range(0, 15) == 0);
               outst         = 1'b1;
               stab_bad      = 1'b0;
               if (!cur.timeout) begin
                  started      = 1'b1;
                  bus.mem_busy = 1'b1;
                  ctl_addr     = bus.mem_addr;
                  bcnt         = (dur_fix != 0) ? dur_fix : int'($urandom_range(2, 10));
               end
            end
         end
      end
      // Controller model: power-up busy window, then busy for bcnt cycles per accepted command
      bus.mem_dout = 16'($urandom);
      if (init_cnt > 0) begin
         init_cnt--;
         if (init_cnt == 0) begin
            bus.mem_busy = 1'b0;
            fall_cyc     = cyc;
         end
      end else if (!started && bus.mem_busy) begin
         bcnt--;
         if (bcnt <= 0) begin
            bus.mem_busy = 1'b0;
            bus.mem_dout = ctrl_data(ctl_addr);
            fall_cyc     = cyc;
         end
      end
   end

   initial begin
      fork
         client(0);
         client(1);
      join_none
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded time limit, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_byte = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
      bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_byte = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
      bus.mem_busy = 1'b1;
      bus.mem_dout = '0;
      busy_cli[0] = 1'b0;
      busy_cli[1] = 1'b0;
      rd_m[0] = '0;
      rd_m[1] = '0;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      #1;
      check("reset_ctrl", 64'({bus.mem_read, bus.mem_write, bus.mem_byte_write, bus.a_ack, bus.b_ack,
                               bus.timeout_err, bus.mem_addr}), 64'(0));
      check("reset_data", 64'({bus.mem_din, bus.a_rdata, bus.b_rdata}), 64'(0));

      // Power-up busy window holds off a pending request
      push_cmd(0, 1'b0, 1'b0, 22'h000ABC, 16'h1111, 0);
      repeat (80) @(negedge clk);
      check("init_hold", 64'(issue_cnt), 64'(0));
      wait_idle(300);
      check("init_issue_once", 64'(issue_cnt), 64'(1));

      // Plain read with a 12-cycle controller
      dur_fix = 12;
      push_cmd(0, 1'b0, 1'b0, 22'h000124, 16'h0000, 0);
      wait_idle(200);
      check("read_beef", 64'(bus.a_rdata), 64'(16'hBEEF));

      // Byte write to the upper byte
      push_cmd(0, 1'b1, 1'b1, 22'h000001, 16'h5A00, 0);
      wait_idle(200);
      check("bytewr_rdata_kept", 64'(bus.a_rdata), 64'(16'hBEEF));
      dur_fix = 0;

      // Both ports held: leave B as last grantee, then four each back to back
      push_cmd(1, 1'b1, 1'b0, 22'h000200, 16'h2222, 0);
      wait_idle(200);
      grant_log.delete();
      for (int i = 0; i < 4; i++) begin
         push_cmd(0, 1'b0, 1'b0, 22'h001000 + 22'(i), 16'h0, 0);
         push_cmd(1, 1'b1, 1'b0, 22'h002000 + 22'(i), 16'h3000 + 16'(i), 0);
      end
      wait_idle(600);
      check("grant_log_len", 64'(grant_log.size() >= 4), 64'(1));
      for (int i = 0; i < 4 && i < grant_log.size(); i++)
         check("grant_order", 64'(grant_log[i]), 64'(RR ? (i % 2) : 0));

      // Controller that never goes busy, then a normal request
      force_ign = 1'b1;
      push_cmd(0, 1'b0, 1'b0, 22'h3FFFFE, 16'h0, 0);
      wait_idle(200);
      force_ign = 1'b0;
      check("timeout_set", 64'(bus.timeout_err), 64'(1));
      push_cmd(0, 1'b0, 1'b1, 22'h000124, 16'h0, 0);
      wait_idle(200);
      check("timeout_sticky", 64'(bus.timeout_err), 64'(1));
      check("after_timeout_read", 64'(bus.a_rdata), 64'(16'hBEEF));

      // Asynchronous reset while the controller is busy
      dur_fix = 30;
      push_cmd(0, 1'b0, 1'b0, 22'h00AAAA, 16'h0, 0);
      begin
         int n = 0;
         while (!(outst && bus.mem_busy && (cyc - cur.issue_cyc) >= 4) && n < 300) begin
            @(negedge clk);
            #1;
            n++;
         end
         check("reach_wait_end", 64'(n < 300), 64'(1));
      end
      dur_fix = 0;
      #2;
      resetn = 1'b0;
      #1;
      check("arst_ctrl", 64'({bus.mem_read, bus.mem_write, bus.mem_byte_write, bus.a_ack, bus.b_ack,
                              bus.timeout_err, bus.mem_addr}), 64'(0));
      check("arst_data", 64'({bus.mem_din, bus.a_rdata, bus.b_rdata}), 64'(0));
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      wait_idle(400);
      check("arst_terr_clear", 64'(bus.timeout_err), 64'(0));

      // Randomized traffic on both ports with occasional controller timeouts
      rand_ign = 1'b1;
      for (int i = 0; i < 150; i++) begin
         push_cmd(int'($urandom_range(0, 1)), 1'($urandom), 1'($urandom), 22'($urandom), 16'($urandom),
                  int'($urandom_range(0, 4)));
      end
      wait_idle(20000);
      rand_ign = 1'b0;
      check("end_idle", 64'(outst), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
